// File: rtl/fifo_joiner2_if.sv
// fifo_joiner2_if: handshake bundle for the two-input stream join.
//   data_in1 / data_in1_valid / data_in1_ready : stream 1 (producer -> joiner)
//   data_in2 / data_in2_valid / data_in2_ready : stream 2 (producer -> joiner)
//   data_out / data_out_valid / data_out_ready : joined stream (joiner -> consumer)
// master: the environment (drives inputs, consumes the joined word)
// slave : the joiner itself
interface fifo_joiner2_if #(
  parameter int unsigned DATA1_WIDTH = 32,
  parameter int unsigned DATA2_WIDTH = 32
);
  logic [DATA1_WIDTH-1:0]             data_in1;
  logic                               data_in1_valid;
  logic                               data_in1_ready;
  logic [DATA2_WIDTH-1:0]             data_in2;
  logic                               data_in2_valid;
  logic                               data_in2_ready;
  logic [DATA1_WIDTH+DATA2_WIDTH-1:0] data_out;
  logic                               data_out_valid;
  logic                               data_out_ready;

  modport master (
    output data_in1, data_in1_valid, data_in2, data_in2_valid, data_out_ready,
    input  data_in1_ready, data_in2_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in1, data_in1_valid, data_in2, data_in2_valid, data_out_ready,
    output data_in1_ready, data_in2_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fifo_joiner2.sv
// fifo_joiner2: joins two independent valid/ready streams into one word.
// Each input owns a 2-entry FIFO, so either side may run up to two words
// ahead of the other. When both FIFOs hold a word and the output register
// is free (or being drained this cycle), the heads are paired into
// data_out = {stream1, stream2} and both FIFOs pop.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : fifo_joiner2_if.slave (both input streams plus the joined output)
module fifo_joiner2 #(
  parameter int unsigned DATA1_WIDTH = 32,
  parameter int unsigned DATA2_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rst,
  fifo_joiner2_if.slave  bus
);

  logic [DATA1_WIDTH-1:0]             buf1 [2];
  logic [DATA2_WIDTH-1:0]             buf2 [2];
  logic                               head1, tail1, head2, tail2;
  logic [1:0]                         count1, count2;
  logic                               out_valid;
  logic [DATA1_WIDTH+DATA2_WIDTH-1:0] out_data;

  logic ready1, ready2, push1, push2, fire;

  // Readiness depends only on state (and rst), never on the input valids.
  always_comb begin
    ready1 = !rst && (count1 != 2'd2);
    ready2 = !rst && (count2 != 2'd2);
    push1  = bus.data_in1_valid && ready1;
    push2  = bus.data_in2_valid && ready2;
    fire   = (count1 != 2'd0) && (count2 != 2'd0) &&
             (!out_valid || bus.data_out_ready);
  end

  assign bus.data_in1_ready = ready1;
  assign bus.data_in2_ready = ready2;
  assign bus.data_out       = out_data;
  assign bus.data_out_valid = out_valid;

  // Payload storage needs no reset: a slot is only read after it is written.
  always_ff @(posedge clk) begin
    if (push1) buf1[tail1] <= bus.data_in1;
    if (push2) buf2[tail2] <= bus.data_in2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head1     <= 1'b0;
      tail1     <= 1'b0;
      head2     <= 1'b0;
      tail2     <= 1'b0;
      count1    <= '0;
      count2    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (push1) tail1 <= ~tail1;
      if (push2) tail2 <= ~tail2;
      if (fire) begin
        head1 <= ~head1;
        head2 <= ~head2;
      end
      // Simultaneous push and pop leaves the count unchanged; the pop reads
      // the old head, which differs from the slot being written.
      count1 <= count1 + {1'b0, push1} - {1'b0, fire};
      count2 <= count2 + {1'b0, push2} - {1'b0, fire};
      if (fire) begin
        out_data  <= {buf1[head1], buf2[head2]};
        out_valid <= 1'b1;
      end else if (out_valid && bus.data_out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_joiner2.sv
module tb_fifo_joiner2;
  localparam int unsigned W1 = 32;
  localparam int unsigned W2 = 32;
  localparam int unsigned WO = W1 + W2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  fifo_joiner2_if #(.DATA1_WIDTH(W1), .DATA2_WIDTH(W2)) bus ();

  fifo_joiner2 #(.DATA1_WIDTH(W1), .DATA2_WIDTH(W2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: words waiting on each side, and the output register.
  logic [W1-1:0] q1 [$];
  logic [W2-1:0] q2 [$];
  logic          m_ov   = 1'b0;
  logic [WO-1:0] m_data = '0;

  logic          acc1, acc2;
  logic [WO-1:0] got [$];
  int            out_cycles [$];
  int            cyc = 0;

  task automatic check(input string tag, input logic [WO-1:0] obs, input logic [WO-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q1.delete();
    q2.delete();
    m_ov   = 1'b0;
    m_data = '0;
  endtask

  task automatic check_outputs();
    check("out_valid", WO'(bus.data_out_valid), WO'(m_ov));
    check("data_out",  bus.data_out, m_data);
    check("ready1",    WO'(bus.data_in1_ready), WO'(!rst && q1.size() != 2));
    check("ready2",    WO'(bus.data_in2_ready), WO'(!rst && q2.size() != 2));
  endtask

  // One clock edge: record handshakes, advance the model, compare.
  task automatic cycle();
    logic          fire;
    logic [W1-1:0] h1;
    logic [W2-1:0] h2;
    if (!rst && bus.data_out_valid && bus.data_out_ready) begin
      got.push_back(bus.data_out);
      out_cycles.push_back(cyc);
    end
    acc1 = bus.data_in1_valid && !rst && q1.size() != 2;
    acc2 = bus.data_in2_valid && !rst && q2.size() != 2;
    fire = !rst && q1.size() != 0 && q2.size() != 0 && (!m_ov || bus.data_out_ready);
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      if (fire) begin
        h1     = q1.pop_front();
        h2     = q2.pop_front();
        m_data = {h1, h2};
        m_ov   = 1'b1;
      end else if (m_ov && bus.data_out_ready) begin
        m_ov = 1'b0;
      end
      if (acc1) q1.push_back(bus.data_in1);
      if (acc2) q2.push_back(bus.data_in2);
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int i1, i2;
    logic [W1-1:0] s1 [100];
    logic [W2-1:0] s2 [100];

    bus.data_in1       = 32'd100;
    bus.data_in2       = 32'd200;
    bus.data_in1_valid = 1'b1;
    bus.data_in2_valid = 1'b1;
    bus.data_out_ready = 1'b1;

    // Reset held with both inputs valid: nothing accepted, readies low.
    #1;
    check("rst_valid", WO'(bus.data_out_valid), '0);
    repeat (5) cycle();
    check("rst_rdy1", WO'(bus.data_in1_ready), '0);
    rst = 1'b0;
    bus.data_in1_valid = 1'b0;
    bus.data_in2_valid = 1'b0;
    #1;
    check("rdy1_after_rst", WO'(bus.data_in1_ready), WO'(1'b1));
    check("rdy2_after_rst", WO'(bus.data_in2_ready), WO'(1'b1));

    // Basic join
    got.delete();
    bus.data_in1 = 32'd666; bus.data_in2 = 32'd7;
    bus.data_in1_valid = 1'b1; bus.data_in2_valid = 1'b1;
    cycle();
    bus.data_in1_valid = 1'b0; bus.data_in2_valid = 1'b0;
    cycle();
    check("join_valid", WO'(bus.data_out_valid), WO'(1'b1));
    check("join_data", bus.data_out, {32'd666, 32'd7});
    cycle();
    check("join_valid_fall", WO'(bus.data_out_valid), '0);
    cycle();
    check("join_count", WO'(got.size()), WO'(1));

    // Skewed arrival
    got.delete();
    bus.data_in1_valid = 1'b1; bus.data_in1 = 32'd1;
    cycle();
    bus.data_in1 = 32'd2;
    cycle();
    bus.data_in1 = 32'd3;
    check("skew_rdy1_full", WO'(bus.data_in1_ready), '0);
    cycle();
    bus.data_in1_valid = 1'b0;
    repeat (10) cycle();
    check("skew_no_out", WO'(got.size()), '0);
    bus.data_in2_valid = 1'b1; bus.data_in2 = 32'd10;
    cycle();
    bus.data_in2 = 32'd20;
    cycle();
    bus.data_in2_valid = 1'b0;
    repeat (4) cycle();
    check("skew_count", WO'(got.size()), WO'(2));
    if (got.size() == 2) begin
      check("skew_w0", got[0], {32'd1, 32'd10});
      check("skew_w1", got[1], {32'd2, 32'd20});
    end
    check("skew_rdy1_back", WO'(bus.data_in1_ready), WO'(1'b1));

    // Output backpressure
    got.delete(); out_cycles.delete();
    bus.data_out_ready = 1'b0;
    i1 = 0; i2 = 0;
    for (int c = 0; c < 8; c++) begin
      bus.data_in1_valid = (i1 < 4); bus.data_in1 = W1'(i1 + 1);
      bus.data_in2_valid = (i2 < 4); bus.data_in2 = W2'(i2 + 11);
      cycle();
      if (acc1) i1++;
      if (acc2) i2++;
    end
    check("bp_acc1", WO'(i1), WO'(3));
    check("bp_acc2", WO'(i2), WO'(3));
    check("bp_hold_valid", WO'(bus.data_out_valid), WO'(1'b1));
    check("bp_hold_data", bus.data_out, {32'd1, 32'd11});
    bus.data_out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      bus.data_in1_valid = (i1 < 4); bus.data_in1 = W1'(i1 + 1);
      bus.data_in2_valid = (i2 < 4); bus.data_in2 = W2'(i2 + 11);
      cycle();
      if (acc1) i1++;
      if (acc2) i2++;
    end
    bus.data_in1_valid = 1'b0; bus.data_in2_valid = 1'b0;
    check("bp_count", WO'(got.size()), WO'(4));
    if (got.size() == 4) begin
      for (int k = 0; k < 4; k++)
        check("bp_word", got[k], {W1'(k + 1), W2'(k + 11)});
      check("bp_back_to_back", WO'(out_cycles[3] - out_cycles[0]), WO'(3));
    end

    // Streaming with random payloads
    for (int k = 0; k < 100; k++) begin
      s1[k] = $urandom;
      s2[k] = $urandom;
    end
    got.delete(); out_cycles.delete();
    i1 = 0; i2 = 0;
    for (int c = 0; c < 400 && got.size() < 100; c++) begin
      bus.data_in1_valid = (i1 < 100); bus.data_in1 = s1[i1 < 100 ? i1 : 0];
      bus.data_in2_valid = (i2 < 100); bus.data_in2 = s2[i2 < 100 ? i2 : 0];
      cycle();
      if (acc1) i1++;
      if (acc2) i2++;
    end
    bus.data_in1_valid = 1'b0; bus.data_in2_valid = 1'b0;
    check("stream_count", WO'(got.size()), WO'(100));
    if (got.size() == 100) begin
      for (int k = 0; k < 100; k++)
        check("stream_word", got[k], {s1[k], s2[k]});
      check("stream_rate", WO'(out_cycles[99] - out_cycles[0]), WO'(99));
    end

    // Random valids, payloads and backpressure against the model
    for (int c = 0; c < 500; c++) begin
      bus.data_in1_valid = ($urandom_range(0, 3) != 0);
      bus.data_in2_valid = ($urandom_range(0, 3) != 0);
      bus.data_in1       = $urandom;
      bus.data_in2       = $urandom;
      bus.data_out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    bus.data_in1_valid = 1'b0; bus.data_in2_valid = 1'b0;
    bus.data_out_ready = 1'b1;
    repeat (6) cycle();

    // Reset mid-operation: output valid, two words buffered on stream 1
    bus.data_out_ready = 1'b0;
    bus.data_in1_valid = 1'b1; bus.data_in1 = 32'hA1;
    bus.data_in2_valid = 1'b1; bus.data_in2 = 32'hB1;
    cycle();
    bus.data_in2_valid = 1'b0; bus.data_in1 = 32'hA2;
    cycle();
    bus.data_in1 = 32'hA3;
    cycle();
    bus.data_in1_valid = 1'b0;
    check("mid_valid_before", WO'(bus.data_out_valid), WO'(1'b1));
    check("mid_rdy1_full", WO'(bus.data_in1_ready), '0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", WO'(bus.data_out_valid), '0);
    check("async_rst_data", bus.data_out, '0);
    check("async_rst_rdy2", WO'(bus.data_in2_ready), '0);
    model_reset();
    repeat (2) cycle();
    rst = 1'b0;
    bus.data_out_ready = 1'b1;
    got.delete();
    bus.data_in1_valid = 1'b1; bus.data_in1 = 32'd5;
    bus.data_in2_valid = 1'b1; bus.data_in2 = 32'd50;
    cycle();
    bus.data_in1_valid = 1'b0; bus.data_in2_valid = 1'b0;
    repeat (4) cycle();
    check("post_rst_count", WO'(got.size()), WO'(1));
    if (got.size() == 1)
      check("post_rst_word", got[0], {32'd5, 32'd50});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
